hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 24 ++
 rtl/hazard_unit_sb_entry_reg.sv | 22 ++
 rtl/hazard_unit.sv | 91 +++++++++
 tb/tb_hazard_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// rtl/hazard_unit_pkg.sv - shared types and constants for the hazard unit
package hazard_unit_pkg;

   localparam int REG_W       = 4;
   localparam int STALL_CNT_W = 16;

   // One in-flight instruction as seen by the hazard logic
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dst;
      logic             wb_en;
      logic             mem_read;
   } sb_entry_t;

   localparam int ENTRY_W = $bits(sb_entry_t);

   // 1 when a read of src by the ID instruction depends on the in-flight entry e
   function automatic logic src_match(input logic use_src,
                                      input logic [REG_W-1:0] src,
                                      input sb_entry_t e);
      return use_src & e.valid & e.wb_en & (e.dst == src);
   endfunction

endpackage

// File: rtl/hazard_unit_sb_entry_reg.sv
// rtl/hazard_unit_sb_entry_reg.sv - resettable scoreboard entry register with bubble load
module sb_entry_reg
   import hazard_unit_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               bubble,
   input  logic [ENTRY_W-1:0] d,
   output logic [ENTRY_W-1:0] q
);

   // Capture the upstream entry, or an all-zero bubble when squashed
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (bubble)
         q <= '0;
      else
         q <= d;
   end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline stall/flush decision and EXE/MEM/WB scoreboard
module hazard_unit
   import hazard_unit_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   forward_en,
   input  logic [REG_W-1:0]       id_src1,
   input  logic [REG_W-1:0]       id_src2,
   input  logic                   id_use_src1,
   input  logic                   id_use_src2,
   input  logic [REG_W-1:0]       id_dst,
   input  logic                   id_wb_en,
   input  logic                   id_mem_read,
   input  logic                   id_valid,
   input  logic                   branch_taken,
   output logic                   hazard,
   output logic                   flush,
   output logic [REG_W-1:0]       mem_dst,
   output logic                   mem_wb_en,
   output logic [REG_W-1:0]       wb_dst,
   output logic                   wb_wb_en,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   sb_entry_t id_entry;
   sb_entry_t exe_q;
   sb_entry_t mem_q;
   sb_entry_t wb_q;
   logic      exe_match;
   logic      mem_match;
   logic      raw_hazard;
   logic      unused_wb_mem_read;

   assign id_entry = '{valid: id_valid, dst: id_dst, wb_en: id_wb_en, mem_read: id_mem_read};

   // EXE takes the ID instruction unless it is being held back or squashed
   sb_entry_reg u_exe (
      .clk    (clk),
      .rst    (rst),
      .bubble (hazard | flush),
      .d      (id_entry),
      .q      (exe_q)
   );

   // MEM and WB simply follow the pipe every cycle
   sb_entry_reg u_mem (
      .clk    (clk),
      .rst    (rst),
      .bubble (1'b0),
      .d      (exe_q),
      .q      (mem_q)
   );

   sb_entry_reg u_wb (
      .clk    (clk),
      .rst    (rst),
      .bubble (1'b0),
      .d      (mem_q),
      .q      (wb_q)
   );

   // Dependency detection; WB is never checked because the register file writes before it reads
   always_comb begin
      exe_match = id_valid & (src_match(id_use_src1, id_src1, exe_q) |
                              src_match(id_use_src2, id_src2, exe_q));
      mem_match = id_valid & (src_match(id_use_src1, id_src1, mem_q) |
                              src_match(id_use_src2, id_src2, mem_q));
      if (forward_en)
         raw_hazard = exe_match & exe_q.mem_read;
      else
         raw_hazard = exe_match | mem_match;
      flush  = branch_taken & ~rst;
      hazard = raw_hazard & ~branch_taken & ~rst;
   end

   assign mem_dst            = mem_q.dst;
   assign mem_wb_en          = mem_q.valid & mem_q.wb_en;
   assign wb_dst             = wb_q.dst;
   assign wb_wb_en           = wb_q.valid & wb_q.wb_en;
   assign unused_wb_mem_read = wb_q.mem_read;

   // Saturating count of cycles spent stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cycles <= '0;
      else if (hazard && (stall_cycles != '1))
         stall_cycles <= stall_cycles + STALL_CNT_W'(1);
   end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit
module tb_hazard_unit;

   logic        clk;
   logic        rst;
   logic        forward_en;
   logic [3:0]  id_src1;
   logic [3:0]  id_src2;
   logic        id_use_src1;
   logic        id_use_src2;
   logic [3:0]  id_dst;
   logic        id_wb_en;
   logic        id_mem_read;
   logic        id_valid;
   logic        branch_taken;
   logic        hazard;
   logic        flush;
   logic [3:0]  mem_dst;
   logic        mem_wb_en;
   logic [3:0]  wb_dst;
   logic        wb_wb_en;
   logic [15:0] stall_cycles;

   logic [27:0] obs;
   logic [27:0] e;
   logic [27:0] exp_q[$];
   int          vectors;
   int          miscompares;

   hazard_unit dut (
      .clk          (clk),
      .rst          (rst),
      .forward_en   (forward_en),
      .id_src1      (id_src1),
      .id_src2      (id_src2),
      .id_use_src1  (id_use_src1),
      .id_use_src2  (id_use_src2),
      .id_dst       (id_dst),
      .id_wb_en     (id_wb_en),
      .id_mem_read  (id_mem_read),
      .id_valid     (id_valid),
      .branch_taken (branch_taken),
      .hazard       (hazard),
      .flush        (flush),
      .mem_dst      (mem_dst),
      .mem_wb_en    (mem_wb_en),
      .wb_dst       (wb_dst),
      .wb_wb_en     (wb_wb_en),
      .stall_cycles (stall_cycles)
   );

   assign obs = {hazard, flush, mem_wb_en, wb_wb_en, mem_dst, wb_dst, stall_cycles};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [27:0] pk(input logic h, input logic f, input logic mwe,
                                      input logic wwe, input logic [3:0] md,
                                      input logic [3:0] wd, input logic [15:0] sc);
      return {h, f, mwe, wwe, md, wd, sc};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [3:0] s1, input logic u1,
                         input logic [3:0] s2, input logic u2, input logic [3:0] d,
                         input logic wb, input logic mr);
      id_valid    = v;
      id_src1     = s1;
      id_use_src1 = u1;
      id_src2     = s2;
      id_use_src2 = u2;
      id_dst      = d;
      id_wb_en    = wb;
      id_mem_read = mr;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b1;
      branch_taken = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      branch_taken = 1'b1;
      forward_en   = 1'b0;
      set_id(1, 3, 1, 3, 1, 3, 1, 1);
      exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 16'd0));
      #2;
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL reset_state: got %h expected %h", obs, e); end
      rst          = 1'b0;
      branch_taken = 1'b0;
   endtask

   task automatic test_load_use();
      do_reset();
      forward_en = 1'b1;
      set_id(1, 0, 0, 0, 0, 3, 1, 1);
      exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 16'd0));
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL lu_issue: got %h expected %h", obs, e); end
      tick();
      set_id(1, 3, 1, 1, 1, 4, 1, 0);
      exp_q.push_back(pk(1, 0, 0, 0, 0, 0, 16'd0));
      exp_q.push_back(pk(0, 0, 1, 0, 3, 0, 16'd1));
      exp_q.push_back(pk(0, 0, 0, 1, 0, 3, 16'd1));
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL lu_hazard: got %h expected %h", obs, e); end
      tick();
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL lu_release: got %h expected %h", obs, e); end
      tick();
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL lu_bubble: got %h expected %h", obs, e); end
   endtask

   task automatic test_no_forward();
      do_reset();
      forward_en = 1'b0;
      set_id(1, 1, 1, 2, 1, 3, 1, 0);
      tick();
      set_id(1, 3, 1, 3, 1, 5, 1, 0);
      exp_q.push_back(pk(1, 0, 0, 0, 0, 0, 16'd0));
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL nf_stall1: got %h expected %h", obs, e); end
      forward_en = 1'b1;
      exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 16'd0));
      #1;
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL nf_fwd_toggle: got %h expected %h", obs, e); end
      forward_en = 1'b0;
      exp_q.push_back(pk(1, 0, 0, 0, 0, 0, 16'd0));
      exp_q.push_back(pk(1, 0, 1, 0, 3, 0, 16'd1));
      exp_q.push_back(pk(0, 0, 0, 1, 0, 3, 16'd2));
      exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 16'd2));
      #1;
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL nf_fwd_back: got %h expected %h", obs, e); end
      tick();
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL nf_stall2: got %h expected %h", obs, e); end
      tick();
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL nf_release: got %h expected %h", obs, e); end
      tick();
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL nf_issue: got %h expected %h", obs, e); end

      do_reset();
      forward_en = 1'b1;
      set_id(1, 1, 1, 2, 1, 3, 1, 0);
      tick();
      set_id(1, 3, 1, 3, 1, 5, 1, 0);
      exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 16'd0));
      exp_q.push_back(pk(0, 0, 1, 0, 3, 0, 16'd0));
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL fw_no_stall: got %h expected %h", obs, e); end
      tick();
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL fw_flow: got %h expected %h", obs, e); end
   endtask

   task automatic test_branch_flush();
      do_reset();
      forward_en = 1'b0;
      set_id(1, 1, 1, 2, 1, 3, 1, 0);
      tick();
      set_id(1, 3, 1, 3, 1, 5, 1, 0);
      branch_taken = 1'b1;
      exp_q.push_back(pk(0, 1, 0, 0, 0, 0, 16'd0));
      #1;
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL br_flush: got %h expected %h", obs, e); end
      tick();
      branch_taken = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      exp_q.push_back(pk(0, 0, 1, 0, 3, 0, 16'd0));
      exp_q.push_back(pk(0, 0, 0, 1, 0, 3, 16'd0));
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL br_after: got %h expected %h", obs, e); end
      tick();
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL br_bubble: got %h expected %h", obs, e); end
   endtask

   task automatic test_mov_pipeline();
      do_reset();
      forward_en = 1'b1;
      set_id(1, 0, 0, 0, 0, 2, 1, 0);
      exp_q.push_back(pk(0, 0, 1, 0, 2, 0, 16'd0));
      exp_q.push_back(pk(0, 0, 0, 1, 0, 2, 16'd0));
      tick();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL mov_mem: got %h expected %h", obs, e); end
      tick();
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL mov_wb: got %h expected %h", obs, e); end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      forward_en = 1'b0;
      set_id(1, 1, 1, 2, 1, 3, 1, 0);
      tick();
      set_id(1, 3, 1, 3, 1, 5, 1, 0);
      exp_q.push_back(pk(1, 0, 1, 0, 3, 0, 16'd1));
      tick();
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL rs_stall: got %h expected %h", obs, e); end
      #2;
      rst          = 1'b1;
      branch_taken = 1'b1;
      exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 16'd0));
      #1;
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL rs_async: got %h expected %h", obs, e); end
      rst          = 1'b0;
      branch_taken = 1'b0;
      exp_q.push_back(pk(0, 0, 1, 0, 5, 0, 16'd0));
      tick();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL rs_reload: got %h expected %h", obs, e); end
   endtask

   task automatic test_saturation();
      logic        m_exe;
      logic        m_mem;
      logic        exp_h;
      logic        bad;
      int          hz_cnt;
      logic [15:0] exp_sc;
      do_reset();
      forward_en = 1'b0;
      set_id(1, 3, 1, 0, 0, 3, 1, 0);
      m_exe  = 1'b0;
      m_mem  = 1'b0;
      bad    = 1'b0;
      hz_cnt = 0;
      exp_sc = 16'd0;
      while (hz_cnt < 65546 && !bad) begin
         exp_h = m_exe | m_mem;
         vectors++;
         if (hazard !== exp_h) begin
            miscompares++;
            bad = 1'b1;
            $display("FAIL sat_hazard: got %b expected %b after %0d stalls", hazard, exp_h, hz_cnt);
         end
         tick();
         if (exp_h) begin
            hz_cnt++;
            if (exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
         end
         m_mem = m_exe;
         m_exe = ~exp_h;
         if (exp_h && hz_cnt == 40000) begin
            vectors++;
            if (stall_cycles !== exp_sc) begin
               miscompares++;
               $display("FAIL sat_mid: got %h expected %h", stall_cycles, exp_sc);
            end
         end
         if (exp_h && hz_cnt == 65540) begin
            exp_q.push_back({12'd0, exp_sc});
            e = exp_q.pop_front(); vectors++;
            if ({12'd0, stall_cycles} !== e) begin
               miscompares++;
               $display("FAIL sat_top: got %h expected %h", stall_cycles, e[15:0]);
            end
         end
      end
      exp_q.push_back({12'd0, 16'hFFFF});
      e = exp_q.pop_front(); vectors++;
      if ({12'd0, stall_cycles} !== e) begin
         miscompares++;
         $display("FAIL sat_hold: got %h expected %h", stall_cycles, e[15:0]);
      end
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      rst          = 1'b1;
      forward_en   = 1'b0;
      branch_taken = 1'b0;
      id_src1      = '0;
      id_src2      = '0;
      id_use_src1  = 1'b0;
      id_use_src2  = 1'b0;
      id_dst       = '0;
      id_wb_en     = 1'b0;
      id_mem_read  = 1'b0;
      id_valid     = 1'b0;
      test_reset();
      test_load_use();
      test_no_forward();
      test_branch_flush();
      test_mov_pipeline();
      test_reset_mid_stall();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
